// File: rtl/dw_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dw_ram_arbiter
// Purpose  : Shares one single-port synchronous RAM between a core port and a
//            granted external port, with starvation and burst limits.
// Revision : 1.0 - initial release
// ============================================================================
module dw_ram_arbiter #(
    parameter int AW         = 11,
    parameter int STARVE_MAX = 8,
    parameter int BURST_MAX  = 16
) (
    input  logic          sysclk,
    input  logic          reset,

    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [31:0]   core_wdata,
    output logic          core_hold,
    output logic [31:0]   core_rdata,

    input  logic          ext_req_r,
    output logic          ext_gnt_r,
    input  logic          ext_valid,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [31:0]   ext_wdata,
    output logic [31:0]   ext_rdata,
    output logic          ext_rvalid,

    output logic          ram_cs,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata
);

    localparam int c_sw = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
    localparam int c_bw = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam logic [c_sw-1:0] c_starve_last = c_sw'(STARVE_MAX - 1);
    localparam logic [c_bw-1:0] c_burst_last  = c_bw'(BURST_MAX - 1);

    typedef enum logic [0:0] {
        ST_CORE = 1'b0,
        ST_EXT  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_sw-1:0] r_starve_cnt;
    logic [c_bw-1:0] r_burst_cnt;
    logic            r_ext_rvalid;
    logic            w_burst_last;
    logic            w_enter_ext;
    logic            w_ext_read;

    assign w_burst_last = (r_burst_cnt == c_burst_last);
    assign w_enter_ext  = (r_state == ST_CORE) && (w_state_nxt == ST_EXT);
    assign w_ext_read   = (r_state == ST_EXT) && ext_valid && !ext_we;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CORE: begin
                if (ext_req_r && (!core_req || (r_starve_cnt == c_starve_last)))
                    w_state_nxt = ST_EXT;
            end
            ST_EXT: begin
                // Burst limit only yields the RAM when the core actually wants it.
                if (!ext_req_r || (w_burst_last && ext_valid && core_req))
                    w_state_nxt = ST_CORE;
            end
            default: w_state_nxt = ST_CORE;
        endcase
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_state <= ST_CORE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (w_enter_ext || !ext_req_r) begin
            r_starve_cnt <= '0;
        end else if ((r_state == ST_CORE) && core_req && (r_starve_cnt != c_starve_last)) begin
            r_starve_cnt <= r_starve_cnt + c_sw'(1);
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_burst_cnt <= '0;
        end else if (w_enter_ext) begin
            r_burst_cnt <= '0;
        end else if ((r_state == ST_EXT) && ext_valid) begin
            r_burst_cnt <= w_burst_last ? '0 : (r_burst_cnt + c_bw'(1));
        end
    end

    // Read strobe tracks the access, not the grant, so it survives a grant drop.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_ext_rvalid <= 1'b0;
        end else begin
            r_ext_rvalid <= w_ext_read;
        end
    end

    always_comb begin
        ram_cs    = core_req;
        ram_we    = core_we;
        ram_addr  = core_addr;
        ram_wdata = core_wdata;
        core_hold = 1'b0;
        if (r_state == ST_EXT) begin
            ram_cs    = ext_valid;
            ram_we    = ext_we;
            ram_addr  = ext_addr;
            ram_wdata = ext_wdata;
            core_hold = core_req;
        end
    end

    assign ext_gnt_r  = (r_state == ST_EXT);
    assign ext_rvalid = r_ext_rvalid;
    assign core_rdata = ram_rdata;
    assign ext_rdata  = ram_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dw_ram_arbiter.sv
`default_nettype none
// Testbench for dw_ram_arbiter: directed scenarios plus randomized traffic,
// all checked against an ownership/memory reference model.
module tb_dw_ram_arbiter;

    localparam int AW         = 11;
    localparam int STARVE_MAX = 8;
    localparam int BURST_MAX  = 16;

    logic          sysclk = 1'b0;
    logic          reset;
    logic          core_req, core_we;
    logic [AW-1:0] core_addr;
    logic [31:0]   core_wdata;
    logic          core_hold;
    logic [31:0]   core_rdata;
    logic          ext_req_r, ext_gnt_r, ext_valid, ext_we;
    logic [AW-1:0] ext_addr;
    logic [31:0]   ext_wdata, ext_rdata;
    logic          ext_rvalid;
    logic          ram_cs, ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    always #5 sysclk = ~sysclk;

    dw_ram_arbiter #(.AW(AW), .STARVE_MAX(STARVE_MAX), .BURST_MAX(BURST_MAX)) dut (
        .sysclk(sysclk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_hold(core_hold), .core_rdata(core_rdata),
        .ext_req_r(ext_req_r), .ext_gnt_r(ext_gnt_r), .ext_valid(ext_valid),
        .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Synchronous single-port RAM, 1-cycle read latency
    logic [31:0] tb_mem [0:(1<<AW)-1];
    always @(posedge sysclk) begin
        if (ram_cs) begin
            if (ram_we) tb_mem[ram_addr] <= ram_wdata;
            ram_rdata <= tb_mem[ram_addr];
        end
    end

    // Reference model state
    logic [31:0] ref_mem [0:(1<<AW)-1];
    bit          m_ext_owner;
    int          m_waited;
    int          m_used;
    bit          m_rv_pend, m_crd_pend;
    logic [31:0] m_rv_data, m_crd_data;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ext_owner = 0;
        m_waited    = 0;
        m_used      = 0;
        m_rv_pend   = 0;
    endtask

    // Check the current cycle against the model, advance the model, then clock.
    task automatic step();
        bit exp_cs, acc_ext, acc_core;
        #1;
        chk("ext_gnt_r", ext_gnt_r, m_ext_owner);
        chk("ext_rvalid", ext_rvalid, m_rv_pend);
        if (m_rv_pend)  chk("ext_rdata", ext_rdata, m_rv_data);
        if (m_crd_pend) chk("core_rdata", core_rdata, m_crd_data);
        chk("core_hold", core_hold, m_ext_owner && core_req);
        exp_cs = m_ext_owner ? ext_valid : core_req;
        chk("ram_cs", ram_cs, exp_cs);
        if (exp_cs) begin
            chk("ram_we", ram_we, m_ext_owner ? ext_we : core_we);
            chk("ram_addr", ram_addr, m_ext_owner ? ext_addr : core_addr);
            if (ram_we) chk("ram_wdata", ram_wdata, m_ext_owner ? ext_wdata : core_wdata);
        end

        acc_ext  = m_ext_owner && ext_valid;
        acc_core = !m_ext_owner && core_req;
        m_rv_pend  = acc_ext && !ext_we;
        m_crd_pend = acc_core && !core_we;
        if (acc_ext) begin
            if (ext_we) ref_mem[ext_addr] = ext_wdata;
            else        m_rv_data = ref_mem[ext_addr];
        end
        if (acc_core) begin
            if (core_we) ref_mem[core_addr] = core_wdata;
            else         m_crd_data = ref_mem[core_addr];
        end

        if (!m_ext_owner) begin
            if (!ext_req_r) begin
                m_waited = 0;
            end else if (!core_req || m_waited == STARVE_MAX - 1) begin
                m_ext_owner = 1;
                m_used      = 0;
                m_waited    = 0;
            end else begin
                m_waited++;
            end
        end else begin
            if (!ext_req_r) begin
                m_ext_owner = 0;
            end else if (ext_valid) begin
                m_used++;
                if (m_used == BURST_MAX) begin
                    m_used = 0;
                    if (core_req) m_ext_owner = 0;
                end
            end
        end
        @(posedge sysclk);
        #1;
    endtask

    task automatic idle_inputs();
        core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
        ext_req_r = 0; ext_valid = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        for (int i = 0; i < (1 << AW); i++) begin
            tb_mem[i]  = '0;
            ref_mem[i] = '0;
        end
        m_crd_pend = 0;
        m_rv_data  = '0;
        m_crd_data = '0;
        model_reset();
        idle_inputs();
        reset = 1'b1;
        @(posedge sysclk);
        #1;

        // Reset state; core rules apply while reset is held
        core_req = 1; core_we = 0; core_addr = 11'd7;
        chk("rst_gnt", ext_gnt_r, 1'b0);
        chk("rst_rvalid", ext_rvalid, 1'b0);
        chk("rst_hold", core_hold, 1'b0);
        step();
        step();
        reset = 1'b0;
        idle_inputs();
        step();

        // Core write then read of address 5
        core_req = 1; core_we = 1; core_addr = 11'd5; core_wdata = 32'hA5A5A5A5;
        step();
        core_we = 0;
        step();
        core_req = 0;
        chk("core_rd5", core_rdata, 32'hA5A5A5A5);
        chk("core_hold_idle", core_hold, 1'b0);
        step();

        // External grant with idle core, write/read address 3
        ext_req_r = 1;
        step();
        chk("gnt_1cyc", ext_gnt_r, 1'b1);
        ext_valid = 1; ext_we = 1; ext_addr = 11'd3; ext_wdata = 32'h3C3C1234;
        step();
        ext_we = 0;
        step();
        ext_valid = 0;
        chk("ext_rvalid3", ext_rvalid, 1'b1);
        chk("ext_rd3", ext_rdata, 32'h3C3C1234);
        step();
        ext_req_r = 0;
        step();
        step();

        // Starvation limit: continuous core traffic, grant after STARVE_MAX cycles
        core_req = 1; core_we = 0; core_addr = 11'd5; ext_req_r = 1;
        k = 0;
        do begin
            step();
            k++;
        end while (ext_gnt_r !== 1'b1 && k < 20);
        chk("grant_latency", k, STARVE_MAX);
        chk("hold_after_grant", core_hold, 1'b1);

        // Burst limit with core waiting: 16 accepted, 17th ignored
        for (int i = 0; i < BURST_MAX; i++) begin
            ext_valid = 1; ext_we = 1; ext_addr = AW'(32 + i); ext_wdata = $urandom;
            step();
        end
        chk("gnt_after_burst", ext_gnt_r, 1'b0);
        chk("hold_after_burst", core_hold, 1'b0);
        ext_addr = 11'd100; ext_wdata = 32'hDEADBEEF;
        step();
        ext_valid = 0; ext_req_r = 0; core_req = 0;
        step();
        core_req = 1; core_we = 0; core_addr = 11'd100;
        step();
        core_req = 0;
        chk("ignored_17th", core_rdata, 32'h0);
        step();

        // Burst limit with idle core: grant kept for 20 accesses
        ext_req_r = 1;
        step();
        for (int i = 0; i < 20; i++) begin
            ext_valid = 1; ext_we = (i < 10); ext_addr = AW'(40 + (i % 10)); ext_wdata = $urandom;
            step();
        end
        ext_valid = 0;
        chk("gnt_held_20", ext_gnt_r, 1'b1);
        step();

        // Reset in the middle of an external read
        ext_valid = 1; ext_we = 0; ext_addr = 11'd3;
        step();
        reset = 1'b1;
        #1;
        chk("rst_mid_gnt", ext_gnt_r, 1'b0);
        chk("rst_mid_rvalid", ext_rvalid, 1'b0);
        model_reset();
        idle_inputs();
        step();
        reset = 1'b0;
        step();
        core_req = 1; core_we = 0; core_addr = 11'd3;
        chk("post_rst_hold", core_hold, 1'b0);
        step();
        core_req = 0;
        step();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) ext_req_r = ~ext_req_r;
            core_req   = ($urandom_range(0, 9) < 7);
            core_we    = $urandom_range(0, 1) == 1;
            core_addr  = AW'($urandom_range(0, 15));
            core_wdata = $urandom;
            ext_valid  = ($urandom_range(0, 9) < 6);
            ext_we     = $urandom_range(0, 1) == 1;
            ext_addr   = AW'($urandom_range(0, 15));
            ext_wdata  = $urandom;
            step();
        end
        idle_inputs();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
